// File: rtl/bus_pipeline_elastic.sv
`default_nettype none
// ============================================================================
// Module   : bus_pipeline_elastic
// Elastic valid/ready skid pipeline (PE -> bus) plus fixed-latency broadcast
// (bus -> PE). Optional synchronous flush port: define BUS_PIPELINE_FLUSH_EN.
// Revision : 1.0
// ============================================================================
module bus_pipeline_elastic #(
    parameter int NUM_PE         = 8,
    parameter int DATA_LEN       = 16,
    parameter int BUS_ADDR_LEN   = 3,
    parameter int NUM_STAGES     = 3,
    parameter int RD_EXTRA_DELAY = 0
) (
    input  logic                                   clk,
    input  logic                                   rstn,
`ifdef BUS_PIPELINE_FLUSH_EN
    input  logic                                   flush,
`endif
    input  logic [NUM_PE-1:0][BUS_ADDR_LEN-1:0]    addr_to_bus,
    input  logic [NUM_PE-1:0][DATA_LEN-1:0]        data_to_bus,
    input  logic [NUM_PE-1:0]                      valid_to_bus,
    output logic [NUM_PE-1:0]                      ready_to_pe,
    output logic [NUM_PE-1:0][BUS_ADDR_LEN-1:0]    addr_to_bus_p,
    output logic [NUM_PE-1:0][DATA_LEN-1:0]        data_to_bus_p,
    output logic [NUM_PE-1:0]                      valid_to_bus_p,
    input  logic [NUM_PE-1:0]                      ready_from_bus,
    input  logic [DATA_LEN-1:0]                    data_bus,
    input  logic [BUS_ADDR_LEN-1:0]                addr_bus,
    input  logic [NUM_PE-1:0]                      wr_to_bus,
    input  logic [NUM_PE-1:0]                      rd_from_bus,
    output logic [NUM_PE-1:0][DATA_LEN-1:0]        data_bus_p,
    output logic [NUM_PE-1:0][BUS_ADDR_LEN-1:0]    addr_bus_p,
    output logic [NUM_PE-1:0]                      wr_to_bus_p,
    output logic [NUM_PE-1:0]                      rd_from_bus_p
);

    localparam int WORD_W = BUS_ADDR_LEN + DATA_LEN;

    logic w_flush;
`ifdef BUS_PIPELINE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    if (NUM_STAGES == 0) begin : g_comb
        assign ready_to_pe    = ready_from_bus;
        assign valid_to_bus_p = valid_to_bus;
        assign addr_to_bus_p  = addr_to_bus;
        assign data_to_bus_p  = data_to_bus;
        assign data_bus_p     = {NUM_PE{data_bus}};
        assign addr_bus_p     = {NUM_PE{addr_bus}};
        assign wr_to_bus_p    = wr_to_bus;
        assign rd_from_bus_p  = rd_from_bus;

        logic w_unused;
        assign w_unused = ^{clk, rstn, w_flush};
    end else begin : g_pipe
        localparam int RD_DEPTH = NUM_STAGES + RD_EXTRA_DELAY;

        for (genvar ch = 0; ch < NUM_PE; ch++) begin : g_ch
            logic [NUM_STAGES-1:0] w_main_vld;
            logic [NUM_STAGES-1:0] w_skid_vld;
            logic [WORD_W-1:0]     w_main_word [NUM_STAGES];

            for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stg
                logic              r_main_vld;
                logic              r_skid_vld;
                logic [WORD_W-1:0] r_main;
                logic [WORD_W-1:0] r_skid;
                logic              w_up_vld;
                logic [WORD_W-1:0] w_up_word;
                logic              w_dn_rdy;
                logic              w_in_xfer;
                logic              w_out_xfer;

                if (s == 0) begin : g_head
                    assign w_up_vld  = valid_to_bus[ch];
                    assign w_up_word = {addr_to_bus[ch], data_to_bus[ch]};
                end else begin : g_body
                    assign w_up_vld  = w_main_vld[s-1];
                    assign w_up_word = w_main_word[s-1];
                end

                if (s == NUM_STAGES - 1) begin : g_tail
                    assign w_dn_rdy = ready_from_bus[ch];
                end else begin : g_mid
                    assign w_dn_rdy = !w_skid_vld[s+1];
                end

                // Ready upstream is simply "skid empty", taken straight from a flop.
                assign w_in_xfer  = w_up_vld && !r_skid_vld;
                assign w_out_xfer = r_main_vld && w_dn_rdy;

                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        r_main_vld <= 1'b0;
                        r_skid_vld <= 1'b0;
                        r_main     <= '0;
                        r_skid     <= '0;
                    end else if (w_flush) begin
                        r_main_vld <= 1'b0;
                        r_skid_vld <= 1'b0;
                    end else if (w_out_xfer || !r_main_vld) begin
                        // Main is free this cycle: refill from skid first to keep order.
                        if (r_skid_vld) begin
                            r_main     <= r_skid;
                            r_main_vld <= 1'b1;
                            r_skid_vld <= 1'b0;
                        end else begin
                            r_main_vld <= w_in_xfer;
                            if (w_in_xfer) begin
                                r_main <= w_up_word;
                            end
                        end
                    end else if (w_in_xfer) begin
                        r_skid     <= w_up_word;
                        r_skid_vld <= 1'b1;
                    end
                end

                assign w_main_vld[s]  = r_main_vld;
                assign w_skid_vld[s]  = r_skid_vld;
                assign w_main_word[s] = r_main;
            end

            assign valid_to_bus_p[ch]                    = w_main_vld[NUM_STAGES-1];
            assign {addr_to_bus_p[ch], data_to_bus_p[ch]} = w_main_word[NUM_STAGES-1];
            assign ready_to_pe[ch]                       = !w_skid_vld[0];
        end

        // Broadcast copies are replicated per PE at stage 0 to split the fanout.
        logic [NUM_PE-1:0][DATA_LEN-1:0]     r_bc_data [NUM_STAGES];
        logic [NUM_PE-1:0][BUS_ADDR_LEN-1:0] r_bc_addr [NUM_STAGES];
        logic [NUM_PE-1:0]                   r_wr      [NUM_STAGES];
        logic [NUM_PE-1:0]                   r_rd      [RD_DEPTH];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int s = 0; s < NUM_STAGES; s++) begin
                    r_bc_data[s] <= '0;
                    r_bc_addr[s] <= '0;
                end
            end else begin
                r_bc_data[0] <= {NUM_PE{data_bus}};
                r_bc_addr[0] <= {NUM_PE{addr_bus}};
                for (int s = 1; s < NUM_STAGES; s++) begin
                    r_bc_data[s] <= r_bc_data[s-1];
                    r_bc_addr[s] <= r_bc_addr[s-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn || w_flush) begin
                for (int s = 0; s < NUM_STAGES; s++) begin
                    r_wr[s] <= '0;
                end
                for (int s = 0; s < RD_DEPTH; s++) begin
                    r_rd[s] <= '0;
                end
            end else begin
                r_wr[0] <= wr_to_bus;
                r_rd[0] <= rd_from_bus;
                for (int s = 1; s < NUM_STAGES; s++) begin
                    r_wr[s] <= r_wr[s-1];
                end
                for (int s = 1; s < RD_DEPTH; s++) begin
                    r_rd[s] <= r_rd[s-1];
                end
            end
        end

        assign data_bus_p    = r_bc_data[NUM_STAGES-1];
        assign addr_bus_p    = r_bc_addr[NUM_STAGES-1];
        assign wr_to_bus_p   = r_wr[NUM_STAGES-1];
        assign rd_from_bus_p = r_rd[RD_DEPTH-1];
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_pipeline_elastic.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_pipeline_elastic
// Self-checking bench: NUM_STAGES=3/RD_EXTRA_DELAY=2 DUT plus NUM_STAGES=0 DUT.
// Revision : 1.0
// ============================================================================
module tb_bus_pipeline_elastic;

    localparam int NPE = 8;
    localparam int DW  = 16;
    localparam int AW  = 3;
    localparam int NS  = 3;
    localparam int RDX = 2;
    localparam int WW  = AW + DW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [NPE-1:0][AW-1:0] addr_to_bus;
    logic [NPE-1:0][DW-1:0] data_to_bus;
    logic [NPE-1:0]         valid_to_bus;
    logic [NPE-1:0]         ready_from_bus;
    logic [DW-1:0]          data_bus;
    logic [AW-1:0]          addr_bus;
    logic [NPE-1:0]         wr_to_bus;
    logic [NPE-1:0]         rd_from_bus;

    logic [NPE-1:0]         ready_to_pe,    z_ready_to_pe;
    logic [NPE-1:0][AW-1:0] addr_to_bus_p,  z_addr_to_bus_p;
    logic [NPE-1:0][DW-1:0] data_to_bus_p,  z_data_to_bus_p;
    logic [NPE-1:0]         valid_to_bus_p, z_valid_to_bus_p;
    logic [NPE-1:0][DW-1:0] data_bus_p,     z_data_bus_p;
    logic [NPE-1:0][AW-1:0] addr_bus_p,     z_addr_bus_p;
    logic [NPE-1:0]         wr_to_bus_p,    z_wr_to_bus_p;
    logic [NPE-1:0]         rd_from_bus_p,  z_rd_from_bus_p;

    logic flush_now;
`ifdef BUS_PIPELINE_FLUSH_EN
    logic flush = 1'b0;
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    bus_pipeline_elastic #(
        .NUM_PE(NPE), .DATA_LEN(DW), .BUS_ADDR_LEN(AW),
        .NUM_STAGES(NS), .RD_EXTRA_DELAY(RDX)
    ) dut (
        .clk(clk), .rstn(rstn),
`ifdef BUS_PIPELINE_FLUSH_EN
        .flush(flush),
`endif
        .addr_to_bus(addr_to_bus), .data_to_bus(data_to_bus),
        .valid_to_bus(valid_to_bus), .ready_to_pe(ready_to_pe),
        .addr_to_bus_p(addr_to_bus_p), .data_to_bus_p(data_to_bus_p),
        .valid_to_bus_p(valid_to_bus_p), .ready_from_bus(ready_from_bus),
        .data_bus(data_bus), .addr_bus(addr_bus),
        .wr_to_bus(wr_to_bus), .rd_from_bus(rd_from_bus),
        .data_bus_p(data_bus_p), .addr_bus_p(addr_bus_p),
        .wr_to_bus_p(wr_to_bus_p), .rd_from_bus_p(rd_from_bus_p)
    );

    bus_pipeline_elastic #(
        .NUM_PE(NPE), .DATA_LEN(DW), .BUS_ADDR_LEN(AW),
        .NUM_STAGES(0), .RD_EXTRA_DELAY(RDX)
    ) dut0 (
        .clk(clk), .rstn(rstn),
`ifdef BUS_PIPELINE_FLUSH_EN
        .flush(flush),
`endif
        .addr_to_bus(addr_to_bus), .data_to_bus(data_to_bus),
        .valid_to_bus(valid_to_bus), .ready_to_pe(z_ready_to_pe),
        .addr_to_bus_p(z_addr_to_bus_p), .data_to_bus_p(z_data_to_bus_p),
        .valid_to_bus_p(z_valid_to_bus_p), .ready_from_bus(ready_from_bus),
        .data_bus(data_bus), .addr_bus(addr_bus),
        .wr_to_bus(wr_to_bus), .rd_from_bus(rd_from_bus),
        .data_bus_p(z_data_bus_p), .addr_bus_p(z_addr_bus_p),
        .wr_to_bus_p(z_wr_to_bus_p), .rd_from_bus_p(z_rd_from_bus_p)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- Broadcast reference: plain delay history ----------------
    logic [DW-1:0]  h_data [8];
    logic [AW-1:0]  h_addr [8];
    logic [NPE-1:0] h_wr   [8];
    logic [NPE-1:0] h_rd   [8];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 8; i++) begin
                h_data[i] = '0; h_addr[i] = '0; h_wr[i] = '0; h_rd[i] = '0;
            end
        end else begin
            for (int i = 7; i > 0; i--) begin
                h_data[i] = h_data[i-1]; h_addr[i] = h_addr[i-1];
                h_wr[i]   = h_wr[i-1];   h_rd[i]   = h_rd[i-1];
            end
            h_data[0] = data_bus; h_addr[0] = addr_bus;
            h_wr[0]   = wr_to_bus; h_rd[0]  = rd_from_bus;
            if (flush_now) begin
                for (int i = 0; i < 8; i++) begin
                    h_wr[i] = '0; h_rd[i] = '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("bc_data", 128'(data_bus_p),    128'({NPE{h_data[NS-1]}}));
        check("bc_addr", 128'(addr_bus_p),    128'({NPE{h_addr[NS-1]}}));
        check("bc_wr",   128'(wr_to_bus_p),   128'(h_wr[NS-1]));
        check("bc_rd",   128'(rd_from_bus_p), 128'(h_rd[NS+RDX-1]));
        check("pass0_ready", 128'(z_ready_to_pe),    128'(ready_from_bus));
        check("pass0_valid", 128'(z_valid_to_bus_p), 128'(valid_to_bus));
        check("pass0_word",  128'({z_addr_to_bus_p, z_data_to_bus_p}), 128'({addr_to_bus, data_to_bus}));
        check("pass0_bc",    128'({z_data_bus_p, z_addr_bus_p[0], z_wr_to_bus_p, z_rd_from_bus_p}),
                             128'({{NPE{data_bus}}, addr_bus, wr_to_bus, rd_from_bus}));
        check("pass0_bcaddr", 128'(z_addr_bus_p), 128'({NPE{addr_bus}}));
    end

    // ---------------- Elastic reference: per-channel FIFO scoreboard ----------------
    logic [WW-1:0]  sb_word [NPE][16];
    int             sb_acc  [NPE][16];
    int             sb_head [NPE];
    int             sb_tail [NPE];
    logic [NPE-1:0] hold_vld = '0;
    logic [WW-1:0]  hold_word [NPE];

    always @(negedge clk) begin : sb_blk
        int occ;
        logic [WW-1:0] w_out;
        if (!rstn || flush_now) begin
            for (int ch = 0; ch < NPE; ch++) begin
                sb_head[ch] = 0; sb_tail[ch] = 0;
            end
            hold_vld = '0;
        end else begin
            for (int ch = 0; ch < NPE; ch++) begin
                occ   = sb_tail[ch] - sb_head[ch];
                w_out = {addr_to_bus_p[ch], data_to_bus_p[ch]};
                if (hold_vld[ch])
                    check("stall_hold", 128'({valid_to_bus_p[ch], w_out}), 128'({1'b1, hold_word[ch]}));
                if (ready_to_pe[ch])
                    check("ready_cap", 128'(occ <= 2*NS-1), 128'(1));
                else
                    check("notready_occ", 128'(occ >= 2), 128'(1));
                if (occ == 0) begin
                    check("empty_no_valid", 128'(valid_to_bus_p[ch]), 128'(0));
                end else if (valid_to_bus_p[ch] && ready_from_bus[ch]) begin
                    check("order", 128'(w_out), 128'(sb_word[ch][sb_head[ch] % 16]));
                    check("latency_min", 128'(cyc - sb_acc[ch][sb_head[ch] % 16] >= NS), 128'(1));
                    sb_head[ch]++;
                end
                hold_vld[ch]  = valid_to_bus_p[ch] && !ready_from_bus[ch];
                hold_word[ch] = w_out;
                if (valid_to_bus[ch] && ready_to_pe[ch]) begin
                    sb_word[ch][sb_tail[ch] % 16] = {addr_to_bus[ch], data_to_bus[ch]};
                    sb_acc[ch][sb_tail[ch] % 16]  = cyc;
                    sb_tail[ch]++;
                end
            end
        end
    end

    // ---------------- Vector table for the NUM_STAGES=0 instance ----------------
    typedef struct {
        logic [NPE-1:0] vld;   logic [NPE-1:0] rdy;
        logic [DW-1:0]  pdata; logic [AW-1:0]  paddr;
        logic [DW-1:0]  dbus;  logic [AW-1:0]  abus;
        logic [NPE-1:0] wr;    logic [NPE-1:0] rd;
        logic [NPE-1:0] e_rdy; logic [NPE-1:0] e_vld;
        logic [DW-1:0]  e_data7; logic [AW-1:0] e_addr7;
        logic [DW-1:0]  e_dbus3; logic [NPE-1:0] e_wr; logic [NPE-1:0] e_rd;
    } vec_t;
    vec_t tbl [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            valid_to_bus = '0; ready_from_bus = '1;
            data_bus = '0; addr_bus = '0; wr_to_bus = '0; rd_from_bus = '0;
        end
    endtask

    initial begin
        int acc;
        int emitted;
        logic [DW-1:0] nxt;

        valid_to_bus = '0; ready_from_bus = '1; addr_to_bus = '0; data_to_bus = '0;
        data_bus = '0; addr_bus = '0; wr_to_bus = '0; rd_from_bus = '0;

        tbl[0] = '{8'hA5, 8'h3C, 16'h1234, 3'd6, 16'hBEEF, 3'd1, 8'h0F, 8'hF0,
                   8'h3C, 8'hA5, 16'h1234, 3'd6, 16'hBEEF, 8'h0F, 8'hF0};
        tbl[1] = '{8'hFF, 8'h00, 16'hFFFF, 3'd7, 16'h0000, 3'd0, 8'h80, 8'h01,
                   8'h00, 8'hFF, 16'hFFFF, 3'd7, 16'h0000, 8'h80, 8'h01};
        tbl[2] = '{8'h00, 8'hFF, 16'h0000, 3'd0, 16'hFFFF, 3'd7, 8'h00, 8'h00,
                   8'hFF, 8'h00, 16'h0000, 3'd0, 16'hFFFF, 8'h00, 8'h00};
        tbl[3] = '{8'h5A, 8'hC3, 16'h8001, 3'd3, 16'h7FFE, 3'd4, 8'h33, 8'hCC,
                   8'hC3, 8'h5A, 16'h8001, 3'd3, 16'h7FFE, 8'h33, 8'hCC};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  128'(ready_to_pe),    128'(8'hFF));
        check("rst_valid",  128'(valid_to_bus_p), 128'(0));
        check("rst_word",   128'({addr_to_bus_p, data_to_bus_p}), 128'(0));
        check("rst_bc",     128'({data_bus_p, addr_bus_p, wr_to_bus_p, rd_from_bus_p}), 128'(0));
        tick();
        rstn = 1'b1;
        idle(3);

        // Table-driven vectors on the combinational instance
        for (int i = 0; i < 4; i++) begin
            tick();
            valid_to_bus = tbl[i].vld; ready_from_bus = tbl[i].rdy;
            for (int ch = 0; ch < NPE; ch++) begin
                data_to_bus[ch] = tbl[i].pdata; addr_to_bus[ch] = tbl[i].paddr;
            end
            data_bus = tbl[i].dbus; addr_bus = tbl[i].abus;
            wr_to_bus = tbl[i].wr; rd_from_bus = tbl[i].rd;
            #1;
            check("tbl_ready", 128'(z_ready_to_pe),      128'(tbl[i].e_rdy));
            check("tbl_valid", 128'(z_valid_to_bus_p),   128'(tbl[i].e_vld));
            check("tbl_data7", 128'(z_data_to_bus_p[7]), 128'(tbl[i].e_data7));
            check("tbl_addr7", 128'(z_addr_to_bus_p[7]), 128'(tbl[i].e_addr7));
            check("tbl_dbus3", 128'(z_data_bus_p[3]),    128'(tbl[i].e_dbus3));
            check("tbl_wr",    128'(z_wr_to_bus_p),      128'(tbl[i].e_wr));
            check("tbl_rd",    128'(z_rd_from_bus_p),    128'(tbl[i].e_rd));
        end
        idle(12);

        // Streaming on channel 0: 0x0001..0x0010, latency NS, one word per cycle
        for (int j = 0; j < 22; j++) begin
            tick();
            valid_to_bus = (j < 16) ? 8'h01 : 8'h00;
            data_to_bus[0] = DW'(j + 1);
            addr_to_bus[0] = 3'd2;
            @(negedge clk);
            check("stream_ready", 128'(ready_to_pe[0]), 128'(1));
            check("stream_valid", 128'(valid_to_bus_p[0]), 128'(j >= 3 && j < 19));
            if (j >= 3 && j < 19)
                check("stream_data", 128'(data_to_bus_p[0]), 128'(j - 2));
        end
        idle(5);

        // Stall channel 2 for 10 cycles while channels 0 and 2 stream
        acc = 0;
        nxt = 16'h0100;
        for (int j = 0; j < 10; j++) begin
            tick();
            ready_from_bus = 8'hFB;
            valid_to_bus   = 8'h05;
            data_to_bus[0] = nxt; data_to_bus[2] = nxt;
            @(negedge clk);
            if (ready_to_pe[2]) begin
                acc++;
                nxt++;
            end
            check("stall_other_ready", 128'(ready_to_pe[0]), 128'(1));
        end
        check("stall_accepted", 128'(acc), 128'(2*NS));
        check("stall_ready_low", 128'(ready_to_pe[2]), 128'(0));
        emitted = 0;
        for (int j = 0; j < 15; j++) begin
            tick();
            valid_to_bus = '0; ready_from_bus = '1;
            @(negedge clk);
            if (j == 0)
                check("stall_release_out", 128'(valid_to_bus_p[2]), 128'(1));
            if (valid_to_bus_p[2] && ready_from_bus[2])
                emitted++;
        end
        check("stall_emitted", 128'(emitted), 128'(acc));

        // Broadcast pulse
        tick();
        data_bus = 16'hBEEF; addr_bus = 3'd5; wr_to_bus = 8'h01; rd_from_bus = 8'h04;
        for (int j = 0; j < 7; j++) begin
            if (j > 0) begin
                tick();
                data_bus = '0; addr_bus = '0; wr_to_bus = '0; rd_from_bus = '0;
            end
            @(negedge clk);
            check("pulse_wr",   128'(wr_to_bus_p),   128'((j == 3) ? 8'h01 : 8'h00));
            check("pulse_rd",   128'(rd_from_bus_p), 128'((j == 5) ? 8'h04 : 8'h00));
            check("pulse_data", 128'(data_bus_p),
                  (j == 3) ? 128'({NPE{16'hBEEF}}) : 128'(0));
        end
        idle(4);

        // Randomised traffic checked by the scoreboard and history models
        for (int j = 0; j < 400; j++) begin
            tick();
            valid_to_bus   = NPE'($urandom);
            ready_from_bus = NPE'($urandom | $urandom);
            for (int ch = 0; ch < NPE; ch++) begin
                data_to_bus[ch] = DW'($urandom);
                addr_to_bus[ch] = AW'($urandom);
            end
            data_bus = DW'($urandom); addr_bus = AW'($urandom);
            wr_to_bus = NPE'($urandom); rd_from_bus = NPE'($urandom);
        end
        idle(20);
        for (int ch = 0; ch < NPE; ch++)
            check("drain_empty", 128'(sb_tail[ch] - sb_head[ch]), 128'(0));

        // Reset asserted mid-burst with a stalled bus
        for (int j = 0; j < 12; j++) begin
            tick();
            valid_to_bus   = '1;
            ready_from_bus = NPE'($urandom);
            for (int ch = 0; ch < NPE; ch++)
                data_to_bus[ch] = DW'($urandom);
            wr_to_bus = NPE'($urandom); rd_from_bus = NPE'($urandom);
        end
        #2;
        rstn = 1'b0;
        valid_to_bus = '0;
        #1;
        check("midrst_valid", 128'(valid_to_bus_p), 128'(0));
        check("midrst_ready", 128'(ready_to_pe),    128'(8'hFF));
        check("midrst_word",  128'({addr_to_bus_p, data_to_bus_p}), 128'(0));
        check("midrst_bc",    128'({wr_to_bus_p, rd_from_bus_p}), 128'(0));
        tick();
        tick();
        rstn = 1'b1;
        valid_to_bus = '0; ready_from_bus = '1; wr_to_bus = '0; rd_from_bus = '0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("postrst_no_stale", 128'(valid_to_bus_p), 128'(0));
            tick();
        end

`ifdef BUS_PIPELINE_FLUSH_EN
        // Fill channel 1 with 2*NS words under stall, then flush
        acc = 0;
        for (int j = 0; j < 20 && acc < 2*NS; j++) begin
            tick();
            ready_from_bus = 8'hFD;
            valid_to_bus   = 8'h02;
            data_to_bus[1] = DW'(16'h0A00 + acc);
            @(negedge clk);
            if (ready_to_pe[1])
                acc++;
        end
        check("flush_fill", 128'(acc), 128'(2*NS));
        tick();
        valid_to_bus = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ready_from_bus = '1;
        @(negedge clk);
        check("flush_valid", 128'(valid_to_bus_p[1]), 128'(0));
        check("flush_ready", 128'(ready_to_pe[1]),    128'(1));
        for (int j = 0; j < 8; j++) begin
            tick();
            @(negedge clk);
            check("flush_no_emit", 128'(valid_to_bus_p[1]), 128'(0));
        end
`endif

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
